// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with flush/hold/bubble and event counters
module pipe_stage_reg #(
  parameter int                 DATA_W     = 160,
  parameter int                 CTRL_W     = 10,
  parameter logic [CTRL_W-1:0]  NOP_CTRL   = '0,
  parameter bit                 CLEAR_DATA = 1'b1,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_bubble,
  output logic [CNT_W-1:0]  cnt_hold
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_t;

  action_t             w_act;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [CNT_W-1:0]    r_cnt_flush;
  logic [CNT_W-1:0]    r_cnt_bubble;
  logic [CNT_W-1:0]    r_cnt_hold;
  logic [DATA_W-1:0]   w_nop_data;

  // A bubble coinciding with hold is dropped: the upstream stage re-presents its instruction.
  always_comb begin
    w_act = ACT_LOAD;
    if (flush) begin
      w_act = ACT_FLUSH;
    end else if (hold) begin
      w_act = ACT_HOLD;
    end else if (bubble) begin
      w_act = ACT_BUBBLE;
    end
  end

  assign w_nop_data = CLEAR_DATA ? '0 : r_data;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= NOP_CTRL;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_valid <= 1'b0;
          r_data  <= w_nop_data;
          r_ctrl  <= NOP_CTRL;
        end
        ACT_HOLD: begin
          r_valid <= r_valid;
          r_data  <= r_data;
          r_ctrl  <= r_ctrl;
        end
        default: begin
          r_valid <= in_valid;
          r_data  <= in_data;
          r_ctrl  <= in_ctrl;
        end
      endcase
    end
  end

  // Counters saturate at all-ones; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!nrst || cnt_clr) begin
      r_cnt_flush  <= '0;
      r_cnt_bubble <= '0;
      r_cnt_hold   <= '0;
    end else begin
      if ((w_act == ACT_FLUSH) && (r_cnt_flush != '1)) begin
        r_cnt_flush <= r_cnt_flush + 1'b1;
      end
      if ((w_act == ACT_BUBBLE) && (r_cnt_bubble != '1)) begin
        r_cnt_bubble <= r_cnt_bubble + 1'b1;
      end
      if ((w_act == ACT_HOLD) && (r_cnt_hold != '1)) begin
        r_cnt_hold <= r_cnt_hold + 1'b1;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_ctrl   = r_ctrl;
  assign cnt_flush  = r_cnt_flush;
  assign cnt_bubble = r_cnt_bubble;
  assign cnt_hold   = r_cnt_hold;

endmodule
